// File: rtl/lane_traffic_scheduler.sv
// Lane traffic scheduler: per-lane spawn/cooldown sequencing with a round-robin
// arbiter that grants at most one car spawn per frame, randomised by a Galois LFSR.

module lane_traffic_scheduler_lane #(
    parameter logic [7:0] INIT_CNT = 8'd0,
    parameter logic [7:0] MIN_GAP  = 8'd30
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       game_active_i,
    input  logic       car_done_i,
    input  logic       grant_i,
    input  logic [9:0] rnd_i,
    output logic       ready_o,
    output logic       spawn_o,
    output logic [1:0] type_o,
    output logic [2:0] speed_o
);
    typedef enum logic [1:0] {IDLE, COOLDOWN, READY, ACTIVE} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       en_q, en_d;
    logic [1:0] type_q, type_d;
    logic [2:0] speed_q, speed_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        type_d  = type_q;
        speed_d = speed_q;
        // Leaving the game overrides everything, including CarDone and a grant.
        if (!game_active_i) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            en_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = COOLDOWN;
                    cnt_d   = INIT_CNT;
                end
                COOLDOWN: begin
                    if (cnt_q == 8'd0) state_d = READY;
                    else               cnt_d   = cnt_q - 8'd1;
                end
                READY: begin
                    if (grant_i) begin
                        state_d = ACTIVE;
                        en_d    = 1'b1;
                        type_d  = (rnd_i[1:0] == 2'd3) ? 2'd0 : rnd_i[1:0];
                        speed_d = {1'b0, rnd_i[3:2]} + 3'd1;
                    end
                end
                ACTIVE: begin
                    if (car_done_i) begin
                        state_d = COOLDOWN;
                        cnt_d   = MIN_GAP + {2'b00, rnd_i[9:4]};
                        en_d    = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            en_q    <= 1'b0;
            type_q  <= 2'd0;
            speed_q <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            type_q  <= type_d;
            speed_q <= speed_d;
        end
    end

    assign ready_o = (state_q == READY);
    assign spawn_o = en_q;
    assign type_o  = type_q;
    assign speed_o = speed_q;
endmodule

module lane_traffic_scheduler #(
    parameter int          NUM_LANES  = 4,
    parameter logic [9:0]  LANE_Y0    = 10'd96,
    parameter logic [9:0]  LANE_PITCH = 10'd32,
    parameter logic [7:0]  MIN_GAP    = 8'd30,
    parameter logic [7:0]  STAGGER    = 8'd20,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    FrameClk,
    input  logic                    Reset,
    input  logic                    GameActive,
    input  logic [NUM_LANES-1:0]    CarDone,
    output logic [NUM_LANES-1:0]    SpawnEnable,
    output logic [2*NUM_LANES-1:0]  LaneType,
    output logic [3*NUM_LANES-1:0]  LaneSpeed,
    output logic [NUM_LANES-1:0]    FaceLeft,
    output logic [10*NUM_LANES-1:0] LaneY
);
    localparam int PW = $clog2(NUM_LANES);

    logic [15:0]          lfsr_q, lfsr_d;
    logic [PW-1:0]        rr_q, rr_d, hit_idx;
    logic                 hit;
    logic [NUM_LANES-1:0] ready, grant;

    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Round-robin: first READY lane at or after rr_q (wrapping) wins.
    always_comb begin
        int k;
        hit     = 1'b0;
        hit_idx = '0;
        grant   = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            k = int'(rr_q) + j;
            if (k >= NUM_LANES) k = k - NUM_LANES;
            if (!hit && ready[k]) begin
                hit     = 1'b1;
                hit_idx = PW'(k);
            end
        end
        rr_d = rr_q;
        if (hit && GameActive) begin
            grant[hit_idx] = 1'b1;
            rr_d = (hit_idx == PW'(NUM_LANES - 1)) ? '0 : hit_idx + PW'(1);
        end
    end

    always_ff @(posedge FrameClk or posedge Reset) begin
        if (Reset) begin
            lfsr_q <= LFSR_SEED;
            rr_q   <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            rr_q   <= rr_d;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [7:0] INIT = 8'(STAGGER * i);

        lane_traffic_scheduler_lane #(
            .INIT_CNT (INIT),
            .MIN_GAP  (MIN_GAP)
        ) u_lane (
            .clk_i         (FrameClk),
            .rst_i         (Reset),
            .game_active_i (GameActive),
            .car_done_i    (CarDone[i]),
            .grant_i       (grant[i]),
            .rnd_i         (lfsr_q[9:0]),
            .ready_o       (ready[i]),
            .spawn_o       (SpawnEnable[i]),
            .type_o        (LaneType[2*i +: 2]),
            .speed_o       (LaneSpeed[3*i +: 3])
        );

        assign FaceLeft[i]        = ((i % 2) == 1);
        assign LaneY[10*i +: 10]  = 10'(LANE_Y0 + LANE_PITCH * i);
    end
endmodule

// File: tb/tb_lane_traffic_scheduler.sv
// Randomised scoreboard bench for lane_traffic_scheduler; the reference model
// tracks each lane by the absolute frame at which it becomes eligible to spawn.

module tb_lane_traffic_scheduler;
    localparam int N       = 4;
    localparam int STAGGER = 20;
    localparam int MIN_GAP = 30;
    localparam int NCYC    = 20000;

    logic             FrameClk = 1'b0;
    logic             Reset;
    logic             GameActive;
    logic [N-1:0]     CarDone;
    logic [N-1:0]     SpawnEnable;
    logic [2*N-1:0]   LaneType;
    logic [3*N-1:0]   LaneSpeed;
    logic [N-1:0]     FaceLeft;
    logic [10*N-1:0]  LaneY;

    always #5 FrameClk = ~FrameClk;

    lane_traffic_scheduler dut (
        .FrameClk    (FrameClk),
        .Reset       (Reset),
        .GameActive  (GameActive),
        .CarDone     (CarDone),
        .SpawnEnable (SpawnEnable),
        .LaneType    (LaneType),
        .LaneSpeed   (LaneSpeed),
        .FaceLeft    (FaceLeft),
        .LaneY       (LaneY)
    );

    typedef struct packed {
        logic [N-1:0]   en;
        logic [2*N-1:0] ty;
        logic [3*N-1:0] sp;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [15:0] m_lfsr;
    int          m_rr;
    int          m_k;
    bit          m_idle [N];
    bit          m_en   [N];
    int          m_rdy  [N];
    int          m_ty   [N];
    int          m_sp   [N];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function void model_reset();
        m_lfsr = 16'hACE1;
        m_rr   = 0;
        for (int i = 0; i < N; i++) begin
            m_idle[i] = 1; m_en[i] = 0; m_rdy[i] = 0; m_ty[i] = 0; m_sp[i] = 0;
        end
    endfunction

    function void model_edge(input bit rst, input bit ga, input logic [N-1:0] done);
        logic [15:0] L;
        int g;
        m_k++;
        if (rst) begin
            model_reset();
            return;
        end
        L = m_lfsr;
        m_lfsr = (L >> 1) ^ (L[0] ? 16'hB400 : 16'h0000);
        if (!ga) begin
            for (int i = 0; i < N; i++) begin m_idle[i] = 1; m_en[i] = 0; end
            return;
        end
        g = -1;
        for (int j = 0; j < N; j++) begin
            int i;
            i = (m_rr + j) % N;
            if (g < 0 && !m_idle[i] && !m_en[i] && m_k >= m_rdy[i]) g = i;
        end
        for (int i = 0; i < N; i++) begin
            if (m_idle[i]) begin
                m_idle[i] = 0;
                m_rdy[i]  = m_k + STAGGER * i + 2;
            end else if (m_en[i]) begin
                if (done[i]) begin
                    m_en[i]  = 0;
                    m_rdy[i] = m_k + MIN_GAP + int'(L[9:4]) + 2;
                end
            end else if (i == g) begin
                m_en[i] = 1;
                m_ty[i] = (L[1:0] == 2'd3) ? 0 : int'(L[1:0]);
                m_sp[i] = int'(L[3:2]) + 1;
            end
        end
        if (g >= 0) m_rr = (g + 1) % N;
    endfunction

    function exp_t model_out();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.en[i]        = m_en[i];
            e.ty[2*i +: 2] = 2'(m_ty[i]);
            e.sp[3*i +: 3] = 3'(m_sp[i]);
        end
        return e;
    endfunction

    // Monitor: outputs settle just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge FrameClk);
            #1;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("SpawnEnable", SpawnEnable, e.en);
                chk("LaneType", LaneType, e.ty);
                chk("LaneSpeed", LaneSpeed, e.sp);
                for (int i = 0; i < N; i++) begin
                    if (SpawnEnable[i]) begin
                        chk("TypeRange", (LaneType[2*i +: 2] == 2'd3), 0);
                        chk("SpeedRange", (LaneSpeed[3*i +: 3] >= 3'd1 && LaneSpeed[3*i +: 3] <= 3'd4), 1);
                    end
                end
            end
        end
    end

    initial begin
        bit           rst_now, ga;
        logic [N-1:0] done;
        logic [N-1:0] fl_exp;
        Reset = 1'b1; GameActive = 1'b0; CarDone = '0;
        m_k = 0;
        model_reset();
        #1;
        chk("RstSpawn", SpawnEnable, 0);
        chk("RstType", LaneType, 0);
        chk("RstSpeed", LaneSpeed, 0);
        for (int i = 0; i < N; i++) begin
            fl_exp[i] = (i % 2 == 1);
            chk("LaneY", LaneY[10*i +: 10], 96 + 32 * i);
        end
        chk("FaceLeft", FaceLeft, fl_exp);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge FrameClk);
            if (cyc < 2) begin
                rst_now = 1; ga = 0; done = '0;
            end else if (cyc < 60) begin
                rst_now = 0; ga = 1; done = '0;
            end else begin
                rst_now = ($urandom_range(0, 2999) == 0);
                ga      = ($urandom_range(0, 299) != 0);
                done    = N'($urandom & $urandom);
            end
            if (rst_now && !Reset) begin
                Reset = 1'b1;
                #1;
                chk("AsyncRstSpawn", SpawnEnable, 0);
                chk("AsyncRstType", LaneType, 0);
                chk("AsyncRstSpeed", LaneSpeed, 0);
            end else begin
                Reset = rst_now;
            end
            GameActive = ga;
            CarDone    = done;
            model_edge(rst_now, ga, done);
            expq.push_back(model_out());
        end
        @(posedge FrameClk);
        #2;
        chk("QueueDrained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
